// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, bit timing helper, data width.
package uart_pkg;

  // Data width shared by uart_rx_fifo and uart_tx.
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBreak
  } rx_state_e;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Offset from the start edge to the middle of the start bit.
  function automatic int unsigned half_bit(input int unsigned clk_hz,
                                           input int unsigned bit_rate);
    return clks_per_bit(clk_hz, bit_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO. A push is accepted when full
// only if a pop happens in the same cycle. Head reads as zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, sticky error flags and a
// receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 24_000_000,
  parameter int unsigned BIT_RATE   = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rxd,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF_BIT     = half_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT + 1);

  logic [1:0]        sync_q;
  logic              rxs;
  rx_state_e         state_q;
  logic [TW-1:0]     tick_q;
  logic [2:0]        bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              overrun_q, frame_err_q;
  logic              last_tick, half_tick, push;
  logic              fifo_full, fifo_empty;

  assign rxs       = sync_q[1];
  assign last_tick = (tick_q == TW'(CLKS_PER_BIT - 1));
  assign half_tick = (tick_q == TW'(HALF_BIT - 1));
  assign push      = (state_q == RxStop) && last_tick && rxs;
  assign rx_valid  = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  // Two-flop synchronizer, preset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rxd};
  end

  // Bit timing FSM and sticky error flags; a new error wins over err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RxIdle;
      tick_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (err_clr) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (push && fifo_full && !rd_en) overrun_q <= 1'b1;
      unique case (state_q)
        RxIdle: begin
          tick_q    <= '0;
          bit_idx_q <= '0;
          if (!rxs) state_q <= RxStart;
        end
        RxStart: begin
          if (half_tick) begin
            tick_q  <= '0;
            state_q <= rxs ? RxIdle : RxData;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        RxData: begin
          if (last_tick) begin
            tick_q    <= '0;
            shift_q   <= {rxs, shift_q[DATA_W-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'(DATA_W - 1)) state_q <= RxStop;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        RxStop: begin
          if (last_tick) begin
            tick_q <= '0;
            if (rxs) begin
              state_q <= RxIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RxBreak;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        RxBreak: begin
          if (rxs) state_q <= RxIdle;
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (208 clk/bit).
module tb_uart_rx_fifo;

  localparam int BIT = 208;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       overrun;
  logic       frame_err;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_rx_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rxd   (uart_rxd),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Drives one 8N1 frame starting at the current negedge; leaves the line high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid);
    end
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
    tests_run++;
    if (rd_data !== 8'h00) begin
      tests_failed++; $display("FAIL reset_rd_data: got %h want 00", rd_data);
    end
    tests_run++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got ovr=%b fe=%b want 0 0", overrun, frame_err);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int n = 0;
    @(negedge clk);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (rx_valid !== 1'b1 && n < 3000) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    // Drive at negedge, two sync flops, detect edge, then 1976 to the stop sample.
    tests_run++;
    if (n !== 1979) begin
      tests_failed++; $display("FAIL a5_latency: got %0d cycles want 1979", n);
    end
    tests_run++;
    if (rd_data !== 8'hA5) begin
      tests_failed++; $display("FAIL a5_data: got %h want a5", rd_data);
    end
    tests_run++;
    if (fifo_count !== 3'd1) begin
      tests_failed++; $display("FAIL a5_count: got %0d want 1", fifo_count);
    end
    pop_one();
    tests_run++;
    if (rx_valid !== 1'b0 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL a5_pop: got valid=%b count=%0d want 0 0", rx_valid, fifo_count);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (50) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2500) @(negedge clk);
    tests_run++;
    if (fifo_count !== 3'd0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch: got count=%0d ovr=%b fe=%b want 0 0 0",
               fifo_count, overrun, frame_err);
    end
    // The receiver must be back in idle and take a normal frame.
    send_frame(8'hC3, 1'b1);
    tests_run++;
    if (rd_data !== 8'hC3 || fifo_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL glitch_recover: got data=%h count=%0d want c3 1", rd_data, fifo_count);
    end
    pop_one();
  endtask

  task automatic test_frame_error();
    @(negedge clk);
    send_frame(8'h3C, 1'b0);
    uart_rxd = 1'b0;
    repeat (500) @(negedge clk);
    uart_rxd = 1'b1;
    // Long enough that a false start in the low period would have completed.
    repeat (1500) @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b1) begin
      tests_failed++; $display("FAIL ferr_flag: got %b want 1", frame_err);
    end
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL ferr_count: got %0d want 0", fifo_count);
    end
    send_frame(8'h55, 1'b1);
    tests_run++;
    if (rd_data !== 8'h55 || fifo_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL ferr_next: got data=%h count=%0d want 55 1", rd_data, fifo_count);
    end
    pop_one();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL ferr_clear: got %b want 0", frame_err);
    end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (10) @(negedge clk);
    tests_run++;
    if (fifo_count !== 3'd4) begin
      tests_failed++; $display("FAIL ovr_count: got %0d want 4", fifo_count);
    end
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_flag: got %b want 1", overrun);
    end
    for (int i = 1; i <= 4; i++) begin
      tests_run++;
      if (rd_data !== 8'(i)) begin
        tests_failed++; $display("FAIL ovr_order%0d: got %h want %h", i, rd_data, 8'(i));
      end
      pop_one();
    end
    tests_run++;
    if (rx_valid !== 1'b0 || rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL ovr_drained: got valid=%b data=%h want 0 00", rx_valid, rd_data);
    end
    // Pop on empty must leave the FIFO untouched.
    pop_one();
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL empty_pop: got %0d want 0", fifo_count);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++; $display("FAIL ovr_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h12; exp[2] = 8'h13; exp[3] = 8'h77;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    tests_run++;
    if (fifo_count !== 3'd4) begin
      tests_failed++; $display("FAIL full_fill: got %0d want 4", fifo_count);
    end
    fork
      send_frame(8'h77, 1'b1);
      begin
        // Stop sample lands on posedge 1979 after the start drive.
        repeat (1978) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    tests_run++;
    if (overrun !== 1'b0 || fifo_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_pp: got ovr=%b count=%0d want 0 4", overrun, fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_data !== exp[i]) begin
        tests_failed++; $display("FAIL full_order%0d: got %h want %h", i, rd_data, exp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    fork
      send_frame(8'h9E, 1'b1);
      begin
        repeat (5 * BIT + 100) @(negedge clk);  // middle of data bit 4
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (rx_valid !== 1'b0 || fifo_count !== 3'd0) begin
          tests_failed++;
          $display("FAIL midrst_hold: got valid=%b count=%0d want 0 0", rx_valid, fifo_count);
        end
        repeat (3 * BIT - 3) @(negedge clk);    // release in data bit 7 (line high)
        reset = 1'b0;
      end
    join
    repeat (2500) @(negedge clk);
    tests_run++;
    if (fifo_count !== 3'd0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_quiet: got count=%0d ovr=%b fe=%b want 0 0 0",
               fifo_count, overrun, frame_err);
    end
    send_frame(8'h12, 1'b1);
    tests_run++;
    if (rd_data !== 8'h12 || fifo_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL midrst_next: got data=%h count=%0d want 12 1", rd_data, fifo_count);
    end
    pop_one();
  endtask

  initial begin
    reset    = 1'b1;
    uart_rxd = 1'b1;
    rd_en    = 1'b0;
    err_clr  = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
